// File: rtl/arith_cmd_sequencer_pkg.sv
// Shared types for the arithmetic command sequencer: FSM states and the queued command record.
package arith_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alufor2.sv
// 8-bit add/subtract unit; y_out[8] is carry for add and not-borrow for subtract.
module alufor2 (
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       control_in,
  output logic [8:0] y_out
);

  always_comb begin
    if (control_in) y_out = {1'b0, a_in} + {1'b0, ~b_in} + 9'd1;
    else            y_out = {1'b0, a_in} + {1'b0, b_in};
  end

endmodule

// File: rtl/arith_cmd_sequencer_fifo.sv
// Synchronous FIFO holding pending commands; push is ignored when full, pop when empty.
module sync_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/arith_cmd_sequencer.sv
// Issues queued add/subtract commands to an external adder one at a time and returns
// each 9-bit result with status flags on a valid/ready handshake, in order.
module arith_cmd_sequencer
  import arith_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic [7:0] cmd_a_in,
  input  logic [7:0] cmd_b_in,
  input  logic       cmd_sub_in,
  output logic [7:0] alu_a_out,
  output logic [7:0] alu_b_out,
  output logic       alu_ctrl_out,
  input  logic [8:0] alu_y_in,
  output logic       res_valid_out,
  input  logic       res_ready_in,
  output logic [7:0] res_out,
  output logic       carry_out,
  output logic       zero_out,
  output logic       ovf_out,
  output logic       neg_out,
  output logic       busy_out
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t         state;
  state_t         state_nxt;
  logic           pop;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_W:0] fifo_count;
  logic [CMD_W-1:0] fifo_rdata;
  cmd_t           head;
  cmd_t           cmd_in;

  logic [7:0] alu_a_p0;
  logic [7:0] alu_b_p0;
  logic       alu_ctrl_p0;
  logic [7:0] res_p1;
  logic [3:0] flags_p1;
  logic       vld_p1;

  // Flags ordered {carry, zero, ovf, neg}; overflow is judged against the operands as issued.
  function automatic logic [3:0] calc_flags(input logic [8:0] y, input logic [7:0] a,
                                            input logic [7:0] b, input logic sub);
    logic ovf;
    if (sub) ovf = (a[7] != b[7]) && (y[7] != a[7]);
    else     ovf = (a[7] == b[7]) && (y[7] != a[7]);
    return {y[8], (y[7:0] == 8'h00), ovf, y[7]};
  endfunction

  assign cmd_in        = '{a: cmd_a_in, b: cmd_b_in, sub: cmd_sub_in};
  assign head          = cmd_t'(fifo_rdata);
  assign cmd_ready_out = (fifo_count != FULL_CNT);
  assign push          = cmd_valid_in && !fifo_full;
  assign busy_out      = (state != ST_IDLE) || !fifo_empty;

  sync_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE:  state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (res_ready_in) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_DRIVE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 drives the adder; stage p1 captures its settled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      alu_a_p0    <= '0;
      alu_b_p0    <= '0;
      alu_ctrl_p0 <= 1'b0;
      res_p1      <= '0;
      flags_p1    <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        alu_a_p0    <= head.a;
        alu_b_p0    <= head.b;
        alu_ctrl_p0 <= head.sub;
      end
      if (state == ST_SAMPLE) begin
        res_p1   <= alu_y_in[7:0];
        flags_p1 <= calc_flags(alu_y_in, alu_a_p0, alu_b_p0, alu_ctrl_p0);
        vld_p1   <= 1'b1;
      end else if (state == ST_HOLD && res_ready_in) begin
        vld_p1   <= 1'b0;
      end
    end
  end

  assign alu_a_out     = alu_a_p0;
  assign alu_b_out     = alu_b_p0;
  assign alu_ctrl_out  = alu_ctrl_p0;
  assign res_valid_out = vld_p1;
  assign res_out       = res_p1;
  assign carry_out     = flags_p1[3];
  assign zero_out      = flags_p1[2];
  assign ovf_out       = flags_p1[1];
  assign neg_out       = flags_p1[0];

endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// Scoreboard bench: accepted commands queue an arithmetic expectation; a monitor checks results.
module tb_arith_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [7:0] cmd_a_in;
  logic [7:0] cmd_b_in;
  logic       cmd_sub_in;
  logic [7:0] alu_a_out;
  logic [7:0] alu_b_out;
  logic       alu_ctrl_out;
  logic [8:0] alu_y_in;
  logic       res_valid_out;
  logic       res_ready_in;
  logic [7:0] res_out;
  logic       carry_out;
  logic       zero_out;
  logic       ovf_out;
  logic       neg_out;
  logic       busy_out;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_res    = 0;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  arith_cmd_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_a_in      (cmd_a_in),
    .cmd_b_in      (cmd_b_in),
    .cmd_sub_in    (cmd_sub_in),
    .alu_a_out     (alu_a_out),
    .alu_b_out     (alu_b_out),
    .alu_ctrl_out  (alu_ctrl_out),
    .alu_y_in      (alu_y_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_out       (res_out),
    .carry_out     (carry_out),
    .zero_out      (zero_out),
    .ovf_out       (ovf_out),
    .neg_out       (neg_out),
    .busy_out      (busy_out)
  );

  alufor2 u_alu (
    .a_in       (alu_a_out),
    .b_in       (alu_b_out),
    .control_in (alu_ctrl_out),
    .y_out      (alu_y_in)
  );

  // Expected {res, carry, zero, ovf, neg} from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u  = sub ? ua - ub : ua + ub;
    s  = sub ? sa - sb : sa + sb;
    r  = u[7:0];
    c  = sub ? (ua >= ub) : (u > 255);
    v  = (s > 127) || (s < -128);
    return {r, c, (r == 8'h00), v, r[7]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (res_valid_out && res_ready_in) begin
        n_res++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got=%h required=none", {res_out, carry_out, zero_out, ovf_out, neg_out});
        end else begin
          logic [11:0] e;
          logic [11:0] g;
          e = exp_q.pop_front();
          g = {res_out, carry_out, zero_out, ovf_out, neg_out};
          if (g !== e) begin
            failures++;
            $display("FAIL result got res=%h cznv_n=%b required res=%h cznv_n=%b", g[11:4], g[3:0], e[11:4], e[3:0]);
          end
        end
      end
      if (cmd_valid_in && cmd_ready_out) begin
        n_acc++;
        exp_q.push_back(model(cmd_a_in, cmd_b_in, cmd_sub_in));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic ok;
    int   n;
    cmd_valid_in = 1'b1;
    cmd_a_in     = a;
    cmd_b_in     = b;
    cmd_sub_in   = sub;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = cmd_ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid_in = 1'b0;
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_out || res_valid_out || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idle_timeout", 32'(n >= 300), 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_valid_timeout", 32'(n >= 50), 32'd0);
  endtask

  initial begin
    int lat;
    int acc0;
    int res0;
    logic rnd_done;
    rst          = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_a_in     = '0;
    cmd_b_in     = '0;
    cmd_sub_in   = 1'b0;
    res_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_res_valid", 32'(res_valid_out), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_out), 32'd1);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_alu", {alu_a_out, alu_b_out, 7'd0, alu_ctrl_out}, 32'd0);
    chk("rst_res", {res_out, carry_out, zero_out, ovf_out, neg_out}, 32'd0);

    // Directed arithmetic corners and issue latency.
    res_ready_in = 1'b1;
    send(8'h7F, 8'h01, 1'b0);
    lat = 0;
    while (!res_valid_out && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_push_to_valid", lat, 3);
    wait_idle();
    send(8'h05, 8'h05, 1'b1);
    wait_idle();
    send(8'h00, 8'h01, 1'b1);
    wait_idle();
    send(8'h80, 8'h01, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("alu_hold_in_idle", {alu_a_out, alu_b_out, 7'd0, alu_ctrl_out}, {8'h80, 8'h01, 8'h01});

    // Back-pressure: seven one-cycle offers, five fit.
    res_ready_in = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 7; i++) begin
      cmd_valid_in = 1'b1;
      cmd_a_in     = 8'(8'h10 * i + 3);
      cmd_b_in     = 8'(8'h21 + i);
      cmd_sub_in   = i[0];
      @(posedge clk);
      #1;
    end
    cmd_valid_in = 1'b0;
    chk("full_accept_count", n_acc - acc0, 5);
    repeat (4) @(posedge clk);
    #1;
    chk("full_cmd_ready", 32'(cmd_ready_out), 32'd0);
    wait_valid();
    res_ready_in = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_first_hs", 32'(cmd_ready_out), 32'd1);
    wait_idle();

    // Reset while holding a result with two commands queued.
    res_ready_in = 1'b0;
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b1);
    send(8'h55, 8'h66, 1'b0);
    wait_valid();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_res_valid", 32'(res_valid_out), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready_out), 32'd1);
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    res0 = n_res;
    res_ready_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_stale_results", n_res - res0, 0);

    // Push and pop on the same edge at count 3, then at count 4.
    res_ready_in = 1'b0;
    send(8'hA0, 8'h01, 1'b0);
    send(8'hA1, 8'h02, 1'b1);
    send(8'hA2, 8'h03, 1'b0);
    send(8'hA3, 8'h04, 1'b1);
    wait_valid();
    acc0 = n_acc;
    cmd_valid_in = 1'b1;
    cmd_a_in = 8'hA4; cmd_b_in = 8'h05; cmd_sub_in = 1'b0;
    res_ready_in = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_in = 1'b0;
    res_ready_in = 1'b0;
    chk("pushpop_cnt3_ready", 32'(cmd_ready_out), 32'd1);
    chk("pushpop_cnt3_acc", n_acc - acc0, 1);
    send(8'hA5, 8'h06, 1'b1);
    wait_valid();
    acc0 = n_acc;
    cmd_valid_in = 1'b1;
    cmd_a_in = 8'hA6; cmd_b_in = 8'h07; cmd_sub_in = 1'b0;
    res_ready_in = 1'b1;
    #1;
    chk("pushpop_cnt4_refused_ready", 32'(cmd_ready_out), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid_in = 1'b0;
    chk("pushpop_cnt4_acc", n_acc - acc0, 0);
    chk("pushpop_cnt4_after_pop", 32'(cmd_ready_out), 32'd1);
    wait_idle();

    // Random traffic with random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          res_ready_in = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        res_ready_in = 1'b1;
      end
    join
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
